mul_div_unit: RTL
=================

# mul_div_unit

Iterative 8-bit multiply/divide unit for the Jac1-8 datapath, sitting beside the single-cycle ALU and feeding the ALU-result input of the register write-value select stage. It accepts one operation per start pulse, runs a shift-add multiply or a restoring divide over DataWidth cycles, and holds a double-width result (low/quotient plus high/remainder) until the next operation.

## Interface
- DataWidth, 8, operand and result-half width.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  operation request; sampled only in IDLE.
- op  input  2  op[0]: 0 = MUL, 1 = DIV; op[1]: 1 = signed (honoured only with MUL_DIV_SIGNED_EN).
- operand_a  input  DataWidth  multiplicand / dividend.
- operand_b  input  DataWidth  multiplier / divisor.
- busy  output  1  high in CALC and DONE; start is ignored while high.
- done  output  1  one-cycle completion pulse.
- result  output  DataWidth  product low byte / quotient.
- result_hi  output  DataWidth  product high byte / remainder.
- div_zero  output  1  set when the last DIV had operand_b = 0; cleared by the next accepted start.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: when start = 1, latch operands and op, load the iteration counter with DataWidth-1, clear div_zero, and go to CALC. Exception: DIV with operand_b = 0 goes directly to DONE with result = all ones, result_hi = operand_a, and div_zero = 1.
- CALC: one iteration per edge. MUL is shift-add into a 2*DataWidth accumulator. DIV is restoring shift-subtract, with the quotient built LSB-first and the remainder kept in the upper half. The last iteration (counter = 0) writes result/result_hi and moves to DONE.
- DONE: done = 1 for one cycle, then unconditionally return to IDLE.
- result, result_hi, and div_zero hold their values through IDLE until the next accepted operation overwrites them.
- Arithmetic: the MUL product is exact at 2*DataWidth bits. Unsigned DIV is floor division. All internal accumulators are 2*DataWidth+1 bits, so no intermediate overflow is possible.
- A start asserted during CALC or DONE is dropped and not queued.
- Reset (any time, including mid-CALC): state IDLE, busy 0, done 0, result 0, result_hi 0, div_zero 0, counter 0.

## Timing
- Let k be the edge that samples start in IDLE.
- busy rises after edge k.
- Normal operation: done is high from edge k+DataWidth to k+DataWidth+1 (k+8 to k+9 at default). busy falls at k+DataWidth+1.
- Divide by zero: done is high from k+1 to k+2.
- result is valid in the same cycle done is high.
- Back-to-back operation: a new start is sampled no earlier than edge k+DataWidth+1, giving a throughput of one operation per DataWidth+1 cycles.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- MUL_DIV_SIGNED_EN defined: op[1] = 1 selects two's-complement operation. Operands are converted to magnitudes at latch time, and sign fix-up is applied on the final iteration edge, so latency is unchanged.
  - Signed MUL gives the signed 2*DataWidth product.
  - Signed DIV truncates toward zero; the remainder takes the dividend's sign.
  - -128 / -1 gives quotient 0x80, remainder 0x00.
  - Signed divide by zero behaves as unsigned (quotient all ones, remainder = dividend).
- MUL_DIV_SIGNED_EN undefined: op[1] is ignored, all operations are unsigned, and no sign logic is generated.

## Structure
- Shared package jac_pkg holds:
  - op encodings MD_OP_MUL, MD_OP_DIV, MD_OP_SIGNED_BIT;
  - the state encoding (IDLE, CALC, DONE);
  - the DataWidth default constant.
- One sub-module is natural: mul_div_signfix (conditional two's-complement negate on 2*DataWidth bits). It is instantiated only under MUL_DIV_SIGNED_EN.

## Test plan
- Unsigned MUL 13 × 11: result 0x8F, result_hi 0x00; done at k+8 exactly one cycle; busy high k..k+8.
- Unsigned MUL 0xFF × 0xFF: result 0x01, result_hi 0xFE. Then unsigned DIV 200 / 7 back-to-back at k+9: quotient 0x1C, remainder 0x04.
- Unsigned DIV 0x55 / 0: done at k+1, result 0xFF, result_hi 0x55, div_zero 1. div_zero clears on the next accepted start.
- start pulsed at k+3 during CALC: ignored, with result unchanged from the first operation. Reset asserted at k+4: all outputs 0 immediately, and the next start behaves normally.
- MUL_DIV_SIGNED_EN: signed -3 × 5 gives result 0xF1, result_hi 0xFF. Signed -7 / 2 gives result 0xFD, result_hi 0xFF. Signed -128 / -1 gives 0x80, 0x00.
- Without MUL_DIV_SIGNED_EN: op = 2'b11 with 0xF9 / 0x02 gives unsigned quotient 0x7C, remainder 0x01.

Source files
------------

// File: rtl/jac_pkg.sv
// Shared Jac1-8 definitions: multiply/divide op encodings, sequencer states and
// the default datapath width.
package jac_pkg;

    localparam int DATA_WIDTH_DEFAULT = 8;

    // op[0] selects the operation kind, op[1] requests two's-complement operands.
    localparam int   MD_OP_TYPE_BIT   = 0;
    localparam int   MD_OP_SIGNED_BIT = 1;
    localparam logic MD_OP_MUL        = 1'b0;
    localparam logic MD_OP_DIV        = 1'b1;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

endpackage : jac_pkg

// File: rtl/mul_div_signfix.sv
// Conditional two's-complement negate used for the signed result fix-up of
// mul_div_unit (only instantiated when MUL_DIV_SIGNED_EN is defined).
module mul_div_signfix
    import jac_pkg::*;
#(
    parameter int Width = 2 * DATA_WIDTH_DEFAULT
) (
    input  logic [Width-1:0] value_i,
    input  logic             negate_i,
    output logic [Width-1:0] value_o
);

    assign value_o = negate_i ? (~value_i + Width'(1)) : value_i;

endmodule : mul_div_signfix

// File: rtl/mul_div_unit.sv
// Iterative shift-add multiply / restoring divide for the Jac1-8 datapath.
// Optional two's-complement support is compiled in with `define MUL_DIV_SIGNED_EN.
module mul_div_unit
    import jac_pkg::*;
#(
    parameter int DataWidth = DATA_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [DataWidth-1:0] operand_a,
    input  logic [DataWidth-1:0] operand_b,
    output logic                 busy,
    output logic                 done,
    output logic [DataWidth-1:0] result,
    output logic [DataWidth-1:0] result_hi,
    output logic                 div_zero
);

    localparam int AccW = 2 * DataWidth + 1;
    localparam int CntW = (DataWidth > 1) ? $clog2(DataWidth) : 1;

    md_state_e            state_q;
    logic [CntW-1:0]      cnt_q;
    logic                 is_div_q;
    logic [AccW-1:0]      acc_q;
    logic [DataWidth-1:0] opnd_q;
    logic                 busy_q;
    logic                 done_q;
    logic [DataWidth-1:0] result_q;
    logic [DataWidth-1:0] result_hi_q;
    logic                 div_zero_q;

    logic                 start_is_div;
    logic [DataWidth-1:0] mag_a;
    logic [DataWidth-1:0] mag_b;
    logic [DataWidth:0]   mul_sum;
    logic [AccW-1:0]      div_shift;
    logic [DataWidth+1:0] div_diff;
    logic [AccW-1:0]      acc_d;
    logic [DataWidth-1:0] final_lo;
    logic [DataWidth-1:0] final_hi;

    assign start_is_div = (op[MD_OP_TYPE_BIT] == MD_OP_DIV);

`ifdef MUL_DIV_SIGNED_EN
    logic                   neg_res_q;
    logic                   neg_rem_q;
    logic                   a_neg;
    logic                   b_neg;
    logic [2*DataWidth-1:0] prod_fix;
    logic [DataWidth-1:0]   quo_fix;
    logic [DataWidth-1:0]   rem_fix;

    // Operands become magnitudes at latch time; the signs are re-applied on the last edge.
    assign a_neg = op[MD_OP_SIGNED_BIT] & operand_a[DataWidth-1];
    assign b_neg = op[MD_OP_SIGNED_BIT] & operand_b[DataWidth-1];
    assign mag_a = a_neg ? (~operand_a + DataWidth'(1)) : operand_a;
    assign mag_b = b_neg ? (~operand_b + DataWidth'(1)) : operand_b;

    mul_div_signfix #(.Width(2 * DataWidth)) u_fix_prod (
        .value_i  (acc_d[2*DataWidth-1:0]),
        .negate_i (~is_div_q & neg_res_q),
        .value_o  (prod_fix)
    );

    mul_div_signfix #(.Width(DataWidth)) u_fix_quo (
        .value_i  (acc_d[DataWidth-1:0]),
        .negate_i (is_div_q & neg_res_q),
        .value_o  (quo_fix)
    );

    mul_div_signfix #(.Width(DataWidth)) u_fix_rem (
        .value_i  (acc_d[2*DataWidth-1:DataWidth]),
        .negate_i (is_div_q & neg_rem_q),
        .value_o  (rem_fix)
    );

    assign final_lo = is_div_q ? quo_fix : prod_fix[DataWidth-1:0];
    assign final_hi = is_div_q ? rem_fix : prod_fix[2*DataWidth-1:DataWidth];
`else
    logic unused_op_signed;

    assign unused_op_signed = op[1];
    assign mag_a    = operand_a;
    assign mag_b    = operand_b;
    assign final_lo = acc_d[DataWidth-1:0];
    assign final_hi = acc_d[2*DataWidth-1:DataWidth];
`endif

    // One iteration of either algorithm; the low half of acc_q holds the multiplier
    // (MUL) or the dividend being shifted out while quotient bits enter at the LSB (DIV).
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch can be inferred.
        acc_d     = acc_q;
        mul_sum   = acc_q[AccW-1:DataWidth] + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q[AccW-2:0], 1'b0};
        div_diff  = {1'b0, div_shift[AccW-1:DataWidth]} - {2'b00, opnd_q};
        if (is_div_q) begin
            if (!div_diff[DataWidth+1]) begin
                acc_d = {div_diff[DataWidth:0], div_shift[DataWidth-1:1], 1'b1};
            end else begin
                acc_d = div_shift;
            end
        end else begin
            acc_d = {1'b0, mul_sum, acc_q[DataWidth-1:1]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= MD_IDLE;
            cnt_q       <= '0;
            is_div_q    <= 1'b0;
            acc_q       <= '0;
            opnd_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            div_zero_q  <= 1'b0;
`ifdef MUL_DIV_SIGNED_EN
            neg_res_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                MD_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        busy_q     <= 1'b1;
                        is_div_q   <= start_is_div;
                        div_zero_q <= 1'b0;
`ifdef MUL_DIV_SIGNED_EN
                        neg_res_q  <= a_neg ^ b_neg;
                        neg_rem_q  <= a_neg;
`endif
                        if (start_is_div && (operand_b == '0)) begin
                            // Divide by zero skips CALC; DONE raises done one edge later.
                            state_q     <= MD_DONE;
                            result_q    <= '1;
                            result_hi_q <= operand_a;
                            div_zero_q  <= 1'b1;
                        end else begin
                            state_q <= MD_CALC;
                            cnt_q   <= CntW'(DataWidth - 1);
                            opnd_q  <= start_is_div ? mag_b : mag_a;
                            acc_q   <= {{(DataWidth + 1){1'b0}}, (start_is_div ? mag_a : mag_b)};
                        end
                    end
                end
                MD_CALC: begin
                    acc_q <= acc_d;
                    if (cnt_q == '0) begin
                        state_q     <= MD_DONE;
                        done_q      <= 1'b1;
                        result_q    <= final_lo;
                        result_hi_q <= final_hi;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                MD_DONE: begin
                    if (done_q) begin
                        state_q <= MD_IDLE;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= MD_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign div_zero  = div_zero_q;

endmodule : mul_div_unit
